// File: rtl/fp_pkg.sv
// fp_pkg
// Shared definitions for the single-precision adder front end:
// field widths, exponent bias, the packed IEEE-754 operand layout and
// the special-value classifiers used by the alignment stage.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 4;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // All-ones exponent with a non-zero fraction.
    function automatic logic is_nan_f(input fp32_t x);
        return (&x.exp) & (|x.frac);
    endfunction

    // All-ones exponent with a zero fraction.
    function automatic logic is_inf_f(input fp32_t x);
        return (&x.exp) & ~(|x.frac);
    endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// fp_rshift_sticky
// Combinational right shifter for the smaller significand. Bits shifted
// off the bottom are ORed into bit 0 so rounding downstream still sees
// them; shift amounts of MANT_W or more collapse to a lone sticky bit.
// Ports:
//   mant_in  - significand before alignment {hidden, frac, G, R, S}
//   shamt    - unsigned exponent difference
//   mant_out - aligned significand with sticky folded into bit 0
module fp_rshift_sticky #(
    parameter int MANT_W  = 27,
    parameter int SHAMT_W = 8
) (
    input  logic [MANT_W-1:0]  mant_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [MANT_W-1:0]  mant_out
);

    logic [MANT_W-1:0] shifted;
    logic [MANT_W-1:0] lost_mask;
    logic              sticky;

    // A mask of the low shamt bits picks out everything that falls off
    // the end; the saturated case never uses the mask, so the shift
    // below only ever sees amounts smaller than MANT_W.
    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        mant_out  = '0;
        if (int'(shamt) >= MANT_W) begin
            sticky   = |mant_in;
            mant_out = {{(MANT_W-1){1'b0}}, sticky};
        end else begin
            shifted   = mant_in >> shamt;
            lost_mask = ~({MANT_W{1'b1}} << shamt);
            sticky    = |(mant_in & lost_mask);
            mant_out  = shifted | {{(MANT_W-1){1'b0}}, sticky};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage
// Front end of the single-precision adder: unpacks both operands, picks
// the larger magnitude, and aligns the smaller significand to it with
// guard/round/sticky bits. Two register stages with valid/ready flow.
// Ports:
//   Clk, Clear            - rising-edge clock, async active-high clear
//   A, B                  - IEEE-754 single operands
//   in_valid / in_ready   - upstream handshake
//   out_valid / out_ready - downstream handshake
//   sign_big, eff_sub     - sign of larger operand, effective subtract
//   exp_out               - effective exponent of larger operand
//   mant_big, mant_small  - aligned significands {hidden, frac, G, R, S}
//   is_nan, is_inf        - special-result flags
module fp_align_stage #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int MANT_W = FRAC_W + 4
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_big,
    output logic              eff_sub,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_big,
    output logic [MANT_W-1:0] mant_small,
    output logic              is_nan,
    output logic              is_inf
);

    import fp_pkg::*;

    fp32_t op_a;
    fp32_t op_b;

    logic [EXP_W-1:0]  eexp_a, eexp_b;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic              a_big;

    logic              c_sign_big, c_eff_sub, c_nan, c_inf;
    logic [EXP_W-1:0]  c_exp_big, c_exp_small, c_d;
    logic [MANT_W-1:0] c_mant_big, c_mant_small;

    logic              v1, v2;
    logic              ready2;

    logic              s1_sign_big, s1_eff_sub, s1_nan, s1_inf;
    logic [EXP_W-1:0]  s1_exp, s1_d;
    logic [MANT_W-1:0] s1_mant_big, s1_mant_small;

    logic [MANT_W-1:0] aligned_small;

    assign op_a = A;
    assign op_b = B;

    // Zero and denormal operands behave as exponent 1 with no hidden bit.
    assign eexp_a = (op_a.exp == '0) ? EXP_W'(1) : op_a.exp;
    assign eexp_b = (op_b.exp == '0) ? EXP_W'(1) : op_b.exp;
    assign mant_a = {|op_a.exp, op_a.frac, 3'b000};
    assign mant_b = {|op_b.exp, op_b.frac, 3'b000};

    // Exponent-then-fraction gives a magnitude compare; ties keep A big.
    assign a_big = {eexp_a, op_a.frac} >= {eexp_b, op_b.frac};

    // Unpack/compare logic feeding the first register stage.
    always_comb begin
        c_sign_big   = a_big ? op_a.sign : op_b.sign;
        c_exp_big    = a_big ? eexp_a : eexp_b;
        c_exp_small  = a_big ? eexp_b : eexp_a;
        c_mant_big   = a_big ? mant_a : mant_b;
        c_mant_small = a_big ? mant_b : mant_a;
        c_d          = c_exp_big - c_exp_small;
        c_eff_sub    = op_a.sign ^ op_b.sign;
        c_nan        = is_nan_f(op_a) | is_nan_f(op_b)
                     | (is_inf_f(op_a) & is_inf_f(op_b) & c_eff_sub);
        c_inf        = (is_inf_f(op_a) | is_inf_f(op_b)) & ~c_nan;
    end

    // Each stage may load when its successor is empty or draining.
    assign ready2   = ~v2 | out_ready;
    assign in_ready = ~v1 | ready2;

    // First stage: holds the unpacked operands and shift distance.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            v1            <= 1'b0;
            s1_sign_big   <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_nan        <= 1'b0;
            s1_inf        <= 1'b0;
            s1_exp        <= '0;
            s1_d          <= '0;
            s1_mant_big   <= '0;
            s1_mant_small <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign_big   <= c_sign_big;
                s1_eff_sub    <= c_eff_sub;
                s1_nan        <= c_nan;
                s1_inf        <= c_inf;
                s1_exp        <= c_exp_big;
                s1_d          <= c_d;
                s1_mant_big   <= c_mant_big;
                s1_mant_small <= c_mant_small;
            end
        end
    end

    fp_rshift_sticky #(
        .MANT_W  (MANT_W),
        .SHAMT_W (EXP_W)
    ) u_shift (
        .mant_in  (s1_mant_small),
        .shamt    (s1_d),
        .mant_out (aligned_small)
    );

    // Second stage drives the outputs directly; its data only changes
    // when a new item moves in, so a stalled result stays put.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            v2         <= 1'b0;
            sign_big   <= 1'b0;
            eff_sub    <= 1'b0;
            exp_out    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            is_nan     <= 1'b0;
            is_inf     <= 1'b0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                sign_big   <= s1_sign_big;
                eff_sub    <= s1_eff_sub;
                exp_out    <= s1_exp;
                mant_big   <= s1_mant_big;
                mant_small <= aligned_small;
                is_nan     <= s1_nan;
                is_inf     <= s1_inf;
            end
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage
// Directed and randomized checks of fp_align_stage against an arithmetic
// reference model and a scoreboard of expected results in order.
module tb_fp_align_stage;

    logic        Clk;
    logic        Clear;
    logic [31:0] A, B;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic        sign_big, eff_sub, is_nan, is_inf;
    logic [7:0]  exp_out;
    logic [26:0] mant_big, mant_small;

    logic [65:0] obs_vec;
    logic [65:0] exp_q[$];
    int          vectors;
    int          miscompares;
    int          accept_count;
    int          emit_count;

    fp_align_stage dut (
        .Clk        (Clk),
        .Clear      (Clear),
        .A          (A),
        .B          (B),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_big   (sign_big),
        .eff_sub    (eff_sub),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .is_nan     (is_nan),
        .is_inf     (is_inf)
    );

    assign obs_vec = {sign_big, eff_sub, exp_out, mant_big, mant_small, is_nan, is_inf};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference result from plain integer arithmetic on the operand values.
    function automatic logic [65:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, eea, eeb, ebig, d;
        longint sa, sb, sbig, ssml, sal;
        logic   abig, sgn, na, nb, ia, ib, nan, inf;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        eea = (ea == 0) ? 1 : ea;
        eeb = (eb == 0) ? 1 : eb;
        sa  = (longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0)) * 8;
        sb  = (longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0)) * 8;
        abig = (eea > eeb) || ((eea == eeb) && (a[22:0] >= b[22:0]));
        sgn  = abig ? a[31] : b[31];
        ebig = abig ? eea : eeb;
        d    = abig ? (eea - eeb) : (eeb - eea);
        sbig = abig ? sa : sb;
        ssml = abig ? sb : sa;
        if (d >= 27) begin
            sal = (ssml != 0) ? 64'd1 : 64'd0;
        end else begin
            sal = ssml >> d;
            if ((sal << d) != ssml) sal = sal | 64'd1;
        end
        na  = (ea == 255) && (a[22:0] != 0);
        nb  = (eb == 255) && (b[22:0] != 0);
        ia  = (ea == 255) && (a[22:0] == 0);
        ib  = (eb == 255) && (b[22:0] == 0);
        nan = na | nb | (ia & ib & (a[31] ^ b[31]));
        inf = (ia | ib) & ~nan;
        return {sgn, a[31] ^ b[31], 8'(ebig), 27'(sbig), 27'(sal), nan, inf};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0) r[30:23] = 8'hFF;
        if (k == 1) r[30:23] = 8'h00;
        if (k == 2) r[22:0]  = 23'h0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, score the handshakes, advance.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic ordy, output logic accepted);
        in_valid  = v;
        A         = a;
        B         = b;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            emit_count++;
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("[TB] FAIL spurious_emit: observed %h expected no output", obs_vec);
            end
            if (exp_q.size() > 0) checkOutput("stream_result", obs_vec, exp_q.pop_front());
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            accept_count++;
            exp_q.push_back(model(a, b));
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [65:0] expv);
        logic acc;
        applyStimulus(1'b1, a, b, 1'b1, acc);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, acc);
        checkOutput({tag, "_valid"}, 66'(out_valid), 66'd1);
        checkOutput(tag, obs_vec, expv);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, acc);
        checkOutput(tag, 66'(exp_q.size()), 66'd0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] pa[4];
        logic [31:0] pb[4];
        int          idx;
        int          base_emit;
        logic [31:0] ra, rb;

        vectors      = 0;
        miscompares  = 0;
        accept_count = 0;
        emit_count   = 0;
        Clear     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'h0;
        B         = 32'h0;

        #2;
        checkOutput("reset_out_valid", 66'(out_valid), 66'd0);
        checkOutput("reset_in_ready", 66'(in_ready), 66'd1);
        checkOutput("reset_outputs", obs_vec, 66'd0);
        @(posedge Clk);
        #3;
        Clear = 1'b0;

        // Directed arithmetic: {sign, effsub, exp, mant_big, mant_small, nan, inf}
        directed("one_plus_one", 32'h3F800000, 32'h3F800000,
                 {1'b0, 1'b0, 8'd127, 27'h4000000, 27'h4000000, 1'b0, 1'b0});
        directed("one_minus_three", 32'h3F800000, 32'hC0400000,
                 {1'b1, 1'b1, 8'd128, 27'h6000000, 27'h2000000, 1'b0, 1'b0});
        directed("sticky_sat", 32'h3F800000, 32'h30800000,
                 {1'b0, 1'b0, 8'd127, 27'h4000000, 27'h0000001, 1'b0, 1'b0});
        directed("inf_minus_inf", 32'h7F800000, 32'hFF800000, model(32'h7F800000, 32'hFF800000));
        checkOutput("inf_minus_inf_nan", 66'(is_nan), 66'd1);
        directed("inf_plus_one", 32'h7F800000, 32'h3F800000, model(32'h7F800000, 32'h3F800000));
        checkOutput("inf_plus_one_inf", 66'(is_inf), 66'd1);
        checkOutput("inf_plus_one_nan", 66'(is_nan), 66'd0);
        directed("qnan_operand", 32'h7FC00000, 32'h12345678, model(32'h7FC00000, 32'h12345678));
        checkOutput("qnan_operand_nan", 66'(is_nan), 66'd1);
        drain("directed_drain");

        // Backpressure: four pairs against a stalled output.
        for (int i = 0; i < 4; i++) begin
            pa[i] = rand_fp();
            pb[i] = rand_fp();
        end
        accept_count = 0;
        base_emit    = emit_count;
        idx          = 0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, pa[idx], pb[idx], 1'b0, acc);
            if (acc) idx++;
        end
        for (int c = 0; c < 2; c++) begin
            in_valid  = 1'b1;
            A         = pa[idx];
            B         = pb[idx];
            out_ready = 1'b0;
            #1;
            checkOutput("bp_in_ready_low", 66'(in_ready), 66'd0);
            checkOutput("bp_out_valid", 66'(out_valid), 66'd1);
            checkOutput("bp_hold", obs_vec, exp_q[0]);
            applyStimulus(1'b1, pa[idx], pb[idx], 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("bp_accepts", 66'(accept_count), 66'd2);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            applyStimulus(1'b1, pa[idx], pb[idx], 1'b1, acc);
            if (acc) idx++;
        end
        checkOutput("bp_all_accepted", 66'(idx), 66'd4);
        drain("bp_drain");
        checkOutput("bp_emit_count", 66'(emit_count - base_emit), 66'd4);

        // Clear while both stages hold data.
        applyStimulus(1'b1, rand_fp(), rand_fp(), 1'b0, acc);
        applyStimulus(1'b1, rand_fp(), rand_fp(), 1'b0, acc);
        in_valid = 1'b0;
        #3;
        Clear = 1'b1;
        #1;
        checkOutput("clr_out_valid", 66'(out_valid), 66'd0);
        checkOutput("clr_outputs", obs_vec, 66'd0);
        checkOutput("clr_in_ready", 66'(in_ready), 66'd1);
        Clear = 1'b0;
        exp_q.delete();
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, acc);
        checkOutput("clr_no_emit", 66'(out_valid), 66'd0);
        ra = rand_fp();
        rb = rand_fp();
        applyStimulus(1'b1, ra, rb, 1'b1, acc);
        checkOutput("clr_latency_1", 66'(out_valid), 66'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, acc);
        checkOutput("clr_latency_2", 66'(out_valid), 66'd1);
        checkOutput("clr_new_result", obs_vec, model(ra, rb));
        drain("clr_drain");

        // Random traffic with random stalls on both sides.
        for (int c = 0; c < 400; c++) begin
            ra = rand_fp();
            rb = rand_fp();
            if ($urandom_range(0, 1) == 1) rb[30:23] = ra[30:23] + 8'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 9) < 7), ra, rb, ($urandom_range(0, 9) < 7), acc);
        end
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
